// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions.
// Provides the response codes and response type used by axi_lite_if and by
// every AXI-Lite slave that sits behind the crossbar.
package axi_lite_pkg;

  typedef logic [1:0] axi_resp_t;

  localparam axi_resp_t RESP_OKAY   = 2'b00;
  localparam axi_resp_t RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite bus bundle (AW/W/B/AR/R channels).
// Parameters: ADDR_WIDTH byte-address width, DATA_WIDTH data width (multiple of 8).
// Modports:
//   master - drives AW/W/AR valid+payload, B/R ready
//   slave  - drives AW/W/AR ready, B/R valid+payload
interface axi_lite_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  import axi_lite_pkg::*;

  logic                    awvalid;
  logic                    awready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;

  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;

  logic                    bvalid;
  logic                    bready;
  axi_resp_t               bresp;

  logic                    arvalid;
  logic                    arready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;

  logic                    rvalid;
  logic                    rready;
  logic [DATA_WIDTH-1:0]   rdata;
  axi_resp_t               rresp;

  modport master (
    output awvalid, awaddr, awprot,
    input  awready,
    output wvalid, wdata, wstrb,
    input  wready,
    input  bvalid, bresp,
    output bready,
    output arvalid, araddr, arprot,
    input  arready,
    input  rvalid, rdata, rresp,
    output rready
  );

  modport slave (
    input  awvalid, awaddr, awprot,
    output awready,
    input  wvalid, wdata, wstrb,
    output wready,
    output bvalid, bresp,
    input  bready,
    input  arvalid, araddr, arprot,
    output arready,
    output rvalid, rdata, rresp,
    input  rready
  );

endinterface

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave register file: N_REGS word registers of DATA_WIDTH bits.
// Two independent channel controllers: a write path (AW/W/B) that accepts
// AW and W in any order and commits when both are present, and a read path
// (AR/R) with one outstanding read.
// Ports:
//   aclk    - single clock
//   aresetn - synchronous active-low reset
//   s_if    - axi_lite_if.slave bus port
//   regs_o  - register contents, register k at [k*DATA_WIDTH +: DATA_WIDTH]
module axi_lite_regfile
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int N_REGS     = 8
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  axi_lite_if.slave                    s_if,
  output logic [N_REGS*DATA_WIDTH-1:0] regs_o
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = ADDR_WIDTH - 2;
  localparam int SEL_W  = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam logic [IDX_W-1:0] N_REGS_IDX = IDX_W'(N_REGS);

  // register storage
  logic [DATA_WIDTH-1:0] regs_q [N_REGS];
  logic [DATA_WIDTH-1:0] regs_d [N_REGS];

  // write path state
  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q,  w_held_d;
  logic [IDX_W-1:0]      aw_idx_q,  aw_idx_d;
  logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
  logic [STRB_W-1:0]     wstrb_q,   wstrb_d;
  logic                  bvalid_q,  bvalid_d;
  axi_resp_t             bresp_q,   bresp_d;

  // read path state
  logic                  rvalid_q,  rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
  axi_resp_t             rresp_q,   rresp_d;

  logic                  aw_hs, w_hs, ar_hs;
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]     wr_strb;
  logic                  wr_commit, wr_in_range, rd_in_range;
  logic [SEL_W-1:0]      wr_sel, rd_sel;

  // Byte-lane offset and protection bits carry no meaning for this block.
  logic unused_bits;
  assign unused_bits = ^{s_if.awaddr[1:0], s_if.araddr[1:0], s_if.awprot, s_if.arprot};

  // Readies are forced low while aresetn is asserted.
  assign s_if.awready = aresetn & ~aw_held_q & ~bvalid_q;
  assign s_if.wready  = aresetn & ~w_held_q  & ~bvalid_q;
  assign s_if.arready = aresetn & ~rvalid_q;

  assign s_if.bvalid = bvalid_q;
  assign s_if.bresp  = bresp_q;
  assign s_if.rvalid = rvalid_q;
  assign s_if.rdata  = rdata_q;
  assign s_if.rresp  = rresp_q;

  assign aw_hs = s_if.awvalid & s_if.awready;
  assign w_hs  = s_if.wvalid  & s_if.wready;
  assign ar_hs = s_if.arvalid & s_if.arready;

  // A handshake this cycle takes precedence over the (empty) holding slot,
  // so the commit can happen on the edge that completes the pair.
  assign wr_idx      = aw_hs ? s_if.awaddr[ADDR_WIDTH-1:2] : aw_idx_q;
  assign wr_data     = w_hs  ? s_if.wdata : wdata_q;
  assign wr_strb     = w_hs  ? s_if.wstrb : wstrb_q;
  assign wr_commit   = (aw_held_q | aw_hs) & (w_held_q | w_hs);
  assign wr_in_range = wr_idx < N_REGS_IDX;
  assign wr_sel      = wr_idx[SEL_W-1:0];

  assign rd_idx      = s_if.araddr[ADDR_WIDTH-1:2];
  assign rd_in_range = rd_idx < N_REGS_IDX;
  assign rd_sel      = rd_idx[SEL_W-1:0];

  always_comb begin
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    aw_idx_d  = aw_idx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    for (int k = 0; k < N_REGS; k++) regs_d[k] = regs_q[k];

    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_idx_d  = s_if.awaddr[ADDR_WIDTH-1:2];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = s_if.wdata;
      wstrb_d  = s_if.wstrb;
    end
    if (bvalid_q && s_if.bready) bvalid_d = 1'b0;

    // Commit only occurs with bvalid low (readies are gated by bvalid),
    // so it never collides with the B handshake above.
    if (wr_commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_in_range ? RESP_OKAY : RESP_SLVERR;
      if (wr_in_range) begin
        for (int k = 0; k < N_REGS; k++) begin
          if (wr_sel == SEL_W'(k)) begin
            for (int b = 0; b < STRB_W; b++) begin
              if (wr_strb[b]) regs_d[k][b*8 +: 8] = wr_data[b*8 +: 8];
            end
          end
        end
      end
    end
  end

  // Reads sample regs_q, so a read on a commit edge returns the old value.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (rvalid_q && s_if.rready) rvalid_d = 1'b0;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      if (rd_in_range) begin
        rdata_d = regs_q[rd_sel];
        rresp_d = RESP_OKAY;
      end else begin
        rdata_d = '0;
        rresp_d = RESP_SLVERR;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_idx_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      for (int k = 0; k < N_REGS; k++) regs_q[k] <= '0;
    end else begin
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      aw_idx_q  <= aw_idx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      for (int k = 0; k < N_REGS; k++) regs_q[k] <= regs_d[k];
    end
  end

  always_comb begin
    regs_o = '0;
    for (int k = 0; k < N_REGS; k++) regs_o[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[k];
  end

endmodule

// File: tb/tb_axi_lite_regfile.sv
module tb_axi_lite_regfile;
  import axi_lite_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 8;

  logic aclk = 1'b0;
  logic aresetn;
  logic [NR*DW-1:0] regs_o;

  axi_lite_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi_lite_regfile #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_REGS(NR)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_if    (bus),
    .regs_o  (regs_o)
  );

  always #5 aclk = ~aclk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 2ms");
    $fatal(1);
  end

  // Reference model: plain array of words, indexed by byte address / 4.
  logic [DW-1:0] model [NR];
  int checks_total  = 0;
  int checks_passed = 0;

  function automatic logic [NR*DW-1:0] model_flat();
    logic [NR*DW-1:0] f;
    for (int k = 0; k < NR; k++) f[k*DW +: DW] = model[k];
    return f;
  endfunction

  function automatic bit addr_ok(logic [AW-1:0] a);
    return (a / 4) < NR;
  endfunction

  function automatic axi_resp_t model_resp(logic [AW-1:0] a);
    return addr_ok(a) ? RESP_OKAY : RESP_SLVERR;
  endfunction

  function automatic void model_write(logic [AW-1:0] a, logic [DW-1:0] d, logic [3:0] s);
    if (addr_ok(a))
      for (int b = 0; b < 4; b++)
        if (s[b]) model[a / 4][b*8 +: 8] = d[b*8 +: 8];
  endfunction

  function automatic logic [DW-1:0] model_read(logic [AW-1:0] a);
    return addr_ok(a) ? model[a / 4] : '0;
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < NR; k++) model[k] = '0;
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle_bus();
    bus.awvalid = 0; bus.awaddr = '0; bus.awprot = '0;
    bus.wvalid  = 0; bus.wdata  = '0; bus.wstrb  = '0;
    bus.bready  = 0;
    bus.arvalid = 0; bus.araddr = '0; bus.arprot = '0;
    bus.rready  = 0;
  endtask

  // Generic write: AW offered from cycle aw_start, W from cycle w_start,
  // B accepted after bdelay wait cycles.
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                          input int aw_start, input int w_start, input int bdelay, input string tag);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    int c = 0;
    while (!(aw_done && w_done) && c < 30) begin
      bus.awvalid = !aw_done && (c >= aw_start);
      bus.awaddr  = a;
      bus.awprot  = 3'($urandom_range(0, 7));
      bus.wvalid  = !w_done && (c >= w_start);
      bus.wdata   = d;
      bus.wstrb   = s;
      #1;
      aw_hs = bus.awvalid && bus.awready;
      w_hs  = bus.wvalid && bus.wready;
      checks_total++;
      if (bus.bvalid !== 1'b0) $display("FAIL %s early_bvalid: got %b want 0", tag, bus.bvalid);
      else checks_passed++;
      @(posedge aclk);
      #1;
      aw_done |= aw_hs;
      w_done  |= w_hs;
      c++;
    end
    bus.awvalid = 0;
    bus.wvalid  = 0;
    checks_total++;
    if (!(aw_done && w_done)) $display("FAIL %s handshake_timeout: aw=%b w=%b want both 1", tag, aw_done, w_done);
    else checks_passed++;
    model_write(a, d, s);
    checks_total++;
    if (bus.bvalid !== 1'b1) $display("FAIL %s bvalid_latency: got %b want 1", tag, bus.bvalid);
    else checks_passed++;
    checks_total++;
    if (bus.bresp !== model_resp(a)) $display("FAIL %s bresp: got %b want %b", tag, bus.bresp, model_resp(a));
    else checks_passed++;
    checks_total++;
    if (regs_o !== model_flat()) $display("FAIL %s regs: got %h want %h", tag, regs_o, model_flat());
    else checks_passed++;
    bus.bready = 0;
    for (int i = 0; i < bdelay; i++) begin
      tick();
      checks_total++;
      if (bus.bvalid !== 1'b1 || bus.bresp !== model_resp(a))
        $display("FAIL %s b_hold: got v=%b r=%b want v=1 r=%b", tag, bus.bvalid, bus.bresp, model_resp(a));
      else checks_passed++;
    end
    bus.bready = 1;
    tick();
    bus.bready = 0;
    checks_total++;
    if (bus.bvalid !== 1'b0) $display("FAIL %s b_clear: got %b want 0", tag, bus.bvalid);
    else checks_passed++;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int rdelay, input string tag);
    bit hs = 0;
    int c = 0;
    logic [DW-1:0] exp_d;
    bus.araddr  = a;
    bus.arprot  = 3'($urandom_range(0, 7));
    bus.arvalid = 1;
    while (!hs && c < 30) begin
      #1;
      hs = bus.arready;
      @(posedge aclk);
      #1;
      c++;
    end
    bus.arvalid = 0;
    exp_d = model_read(a);
    checks_total++;
    if (!hs) $display("FAIL %s ar_timeout: got no arready want arready=1", tag);
    else checks_passed++;
    for (int i = 0; i <= rdelay; i++) begin
      checks_total++;
      if (bus.rvalid !== 1'b1 || bus.rdata !== exp_d || bus.rresp !== model_resp(a))
        $display("FAIL %s r_data: got v=%b d=%h r=%b want v=1 d=%h r=%b", tag,
                 bus.rvalid, bus.rdata, bus.rresp, exp_d, model_resp(a));
      else checks_passed++;
      if (i < rdelay) tick();
    end
    bus.rready = 1;
    tick();
    bus.rready = 0;
    checks_total++;
    if (bus.rvalid !== 1'b0) $display("FAIL %s r_clear: got %b want 0", tag, bus.rvalid);
    else checks_passed++;
  endtask

  task automatic test_reset();
    idle_bus();
    aresetn = 0;
    tick();
    tick();
    checks_total++;
    if ({bus.awready, bus.wready, bus.arready} !== 3'b000)
      $display("FAIL reset_readies: got %b want 000", {bus.awready, bus.wready, bus.arready});
    else checks_passed++;
    checks_total++;
    if ({bus.bvalid, bus.rvalid, bus.bresp, bus.rresp} !== 6'b0 || bus.rdata !== '0)
      $display("FAIL reset_outputs: got bv=%b rv=%b br=%b rr=%b rd=%h want all 0",
               bus.bvalid, bus.rvalid, bus.bresp, bus.rresp, bus.rdata);
    else checks_passed++;
    checks_total++;
    if (regs_o !== '0) $display("FAIL reset_regs: got %h want 0", regs_o);
    else checks_passed++;
    model_clear();
    aresetn = 1;
    #1;
    checks_total++;
    if ({bus.awready, bus.wready, bus.arready} !== 3'b111)
      $display("FAIL reset_release_readies: got %b want 111", {bus.awready, bus.wready, bus.arready});
    else checks_passed++;
    tick();
  endtask

  task automatic test_same_cycle();
    do_write(32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0, "same_cycle");
    checks_total++;
    if (regs_o[1*DW +: DW] !== 32'hDEADBEEF)
      $display("FAIL same_cycle_reg1: got %h want deadbeef", regs_o[1*DW +: DW]);
    else checks_passed++;
  endtask

  task automatic test_w_before_aw();
    do_write(32'h8, 32'hAABBCCDD, 4'hF, 0, 0, 0, "preset_reg2");
    bus.wvalid = 1; bus.wdata = 32'h11223344; bus.wstrb = 4'b0101;
    #1;
    checks_total++;
    if (bus.wready !== 1'b1) $display("FAIL wfirst_wready_idle: got %b want 1", bus.wready);
    else checks_passed++;
    tick();
    bus.wvalid = 0;
    for (int i = 0; i < 3; i++) begin
      checks_total++;
      if (bus.wready !== 1'b0 || bus.awready !== 1'b1 || bus.bvalid !== 1'b0)
        $display("FAIL wfirst_wait: got wr=%b awr=%b bv=%b want wr=0 awr=1 bv=0",
                 bus.wready, bus.awready, bus.bvalid);
      else checks_passed++;
      if (i < 2) tick();
    end
    bus.awvalid = 1; bus.awaddr = 32'h8;
    tick();
    bus.awvalid = 0;
    model_write(32'h8, 32'h11223344, 4'b0101);
    checks_total++;
    if (bus.bvalid !== 1'b1 || bus.bresp !== RESP_OKAY)
      $display("FAIL wfirst_b: got bv=%b br=%b want bv=1 br=00", bus.bvalid, bus.bresp);
    else checks_passed++;
    checks_total++;
    if (regs_o[2*DW +: DW] !== 32'hAA22CC44 || regs_o !== model_flat())
      $display("FAIL wfirst_reg2: got %h want aa22cc44", regs_o[2*DW +: DW]);
    else checks_passed++;
    bus.bready = 1;
    tick();
    bus.bready = 0;
  endtask

  task automatic test_out_of_range();
    logic [NR*DW-1:0] snap;
    snap = model_flat();
    do_write(32'h20, 32'($urandom), 4'hF, 0, 0, 1, "oor_write");
    checks_total++;
    if (regs_o !== snap) $display("FAIL oor_regs_unchanged: got %h want %h", regs_o, snap);
    else checks_passed++;
    do_read(32'h20, 0, "oor_read");
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d, exp_r;
    d = 32'($urandom);
    exp_r = model_read(32'h4);
    bus.bready = 0; bus.rready = 0;
    bus.awvalid = 1; bus.awaddr = 32'h14;
    bus.wvalid = 1; bus.wdata = d; bus.wstrb = 4'hF;
    bus.arvalid = 1; bus.araddr = 32'h4;
    tick();
    bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
    model_write(32'h14, d, 4'hF);
    for (int i = 0; i < 5; i++) begin
      checks_total++;
      if (bus.bvalid !== 1'b1 || bus.bresp !== RESP_OKAY || bus.rvalid !== 1'b1 ||
          bus.rdata !== exp_r || bus.rresp !== RESP_OKAY)
        $display("FAIL bp_hold: got bv=%b br=%b rv=%b rd=%h rr=%b want 1 00 1 %h 00",
                 bus.bvalid, bus.bresp, bus.rvalid, bus.rdata, bus.rresp, exp_r);
      else checks_passed++;
      checks_total++;
      if ({bus.awready, bus.wready, bus.arready} !== 3'b000)
        $display("FAIL bp_readies: got %b want 000", {bus.awready, bus.wready, bus.arready});
      else checks_passed++;
      tick();
    end
    bus.bready = 1; bus.rready = 1;
    tick();
    bus.bready = 0; bus.rready = 0;
    checks_total++;
    if (bus.bvalid !== 1'b0 || bus.rvalid !== 1'b0)
      $display("FAIL bp_clear: got bv=%b rv=%b want 0 0", bus.bvalid, bus.rvalid);
    else checks_passed++;
    checks_total++;
    if ({bus.awready, bus.wready, bus.arready} !== 3'b111 || regs_o !== model_flat())
      $display("FAIL bp_after: got rdy=%b regs=%h want 111 %h",
               {bus.awready, bus.wready, bus.arready}, regs_o, model_flat());
    else checks_passed++;
  endtask

  task automatic test_read_during_commit();
    logic [DW-1:0] old_v;
    do_write(32'hC, 32'h5, 4'hF, 0, 0, 0, "preset_reg3");
    old_v = model_read(32'hC);
    bus.awvalid = 1; bus.awaddr = 32'hC;
    bus.wvalid = 1; bus.wdata = 32'h9; bus.wstrb = 4'hF;
    bus.arvalid = 1; bus.araddr = 32'hC;
    tick();
    bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
    model_write(32'hC, 32'h9, 4'hF);
    checks_total++;
    if (bus.rvalid !== 1'b1 || bus.rdata !== old_v || old_v !== 32'h5)
      $display("FAIL rdc_old_value: got rv=%b rd=%h want rv=1 rd=00000005", bus.rvalid, bus.rdata);
    else checks_passed++;
    checks_total++;
    if (regs_o[3*DW +: DW] !== 32'h9 || bus.bvalid !== 1'b1)
      $display("FAIL rdc_commit: got reg3=%h bv=%b want 00000009 1", regs_o[3*DW +: DW], bus.bvalid);
    else checks_passed++;
    bus.bready = 1; bus.rready = 1;
    tick();
    bus.bready = 0; bus.rready = 0;
    do_read(32'hC, 0, "rdc_new_value");
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d;
    // held AW plus pending R
    bus.awvalid = 1; bus.awaddr = 32'h10;
    bus.arvalid = 1; bus.araddr = 32'h8;
    tick();
    bus.awvalid = 0; bus.arvalid = 0;
    checks_total++;
    if (bus.rvalid !== 1'b1 || bus.awready !== 1'b0)
      $display("FAIL mid_setup: got rv=%b awr=%b want 1 0", bus.rvalid, bus.awready);
    else checks_passed++;
    aresetn = 0;
    tick();
    model_clear();
    checks_total++;
    if (bus.bvalid !== 1'b0 || bus.rvalid !== 1'b0 || regs_o !== model_flat())
      $display("FAIL mid_reset_state: got bv=%b rv=%b regs=%h want 0 0 0", bus.bvalid, bus.rvalid, regs_o);
    else checks_passed++;
    aresetn = 1;
    #1;
    checks_total++;
    if ({bus.awready, bus.wready, bus.arready} !== 3'b111)
      $display("FAIL mid_release_readies: got %b want 111", {bus.awready, bus.wready, bus.arready});
    else checks_passed++;
    tick();
    // the discarded AW must not pair with a fresh W
    d = 32'($urandom);
    bus.wvalid = 1; bus.wdata = d; bus.wstrb = 4'hF;
    tick();
    bus.wvalid = 0;
    checks_total++;
    if (bus.bvalid !== 1'b0 || regs_o !== model_flat())
      $display("FAIL mid_aw_discarded: got bv=%b regs=%h want 0 %h", bus.bvalid, regs_o, model_flat());
    else checks_passed++;
    bus.awvalid = 1; bus.awaddr = 32'h10;
    tick();
    bus.awvalid = 0;
    model_write(32'h10, d, 4'hF);
    checks_total++;
    if (bus.bvalid !== 1'b1 || regs_o !== model_flat())
      $display("FAIL mid_late_aw: got bv=%b regs=%h want 1 %h", bus.bvalid, regs_o, model_flat());
    else checks_passed++;
    // reset with B pending
    aresetn = 0;
    tick();
    model_clear();
    checks_total++;
    if (bus.bvalid !== 1'b0 || regs_o !== model_flat())
      $display("FAIL mid_b_discard: got bv=%b regs=%h want 0 0", bus.bvalid, regs_o);
    else checks_passed++;
    aresetn = 1;
    #1;
    checks_total++;
    if ({bus.awready, bus.wready, bus.arready} !== 3'b111)
      $display("FAIL mid_b_release_readies: got %b want 111", {bus.awready, bus.wready, bus.arready});
    else checks_passed++;
    tick();
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    for (int n = 0; n < 40; n++) begin
      a = AW'($urandom_range(0, 9) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 2) < 2)
        do_write(a, 32'($urandom), 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 2), "rand_write");
      else
        do_read(a, $urandom_range(0, 2), "rand_read");
    end
    checks_total++;
    if (regs_o !== model_flat()) $display("FAIL rand_final_regs: got %h want %h", regs_o, model_flat());
    else checks_passed++;
  endtask

  initial begin
    idle_bus();
    aresetn = 0;
    model_clear();
    test_reset();
    test_same_cycle();
    test_w_before_aw();
    test_out_of_range();
    test_backpressure();
    test_read_during_commit();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/axi_lite_regfile.md
AXI_LITE_REGFILE -- requirements
Module: axi_lite_regfile

Interface
REQ-001 The parameter ADDR_WIDTH SHALL default to 32 and set the byte-address width.
REQ-002 The parameter DATA_WIDTH SHALL default to 32 and set the register and data width (multiple of 8).
REQ-003 The parameter N_REGS SHALL default to 8 and set the number of word registers.
REQ-004 The port aclk SHALL be an input, 1 bit wide, and the single clock; there SHALL be one clock only.
REQ-005 The port aresetn SHALL be an input, 1 bit wide, and the reset, synchronous and active-low.
REQ-006 The port s_if SHALL be an axi_lite_if.slave modport carrying the AW/W/B/AR/R channels; it is the port fed by one crossbar m_peri_if.
REQ-007 The port regs_o SHALL be an output, N_REGS*DATA_WIDTH bits wide, carrying the register contents (register k at bits [k*DATA_WIDTH +: DATA_WIDTH]).

Function
REQ-008 Register index SHALL be addr[ADDR_WIDTH-1:2]; addr[1:0], awprot and arprot SHALL be ignored.
REQ-009 An index >= N_REGS SHALL be out-of-range: writes have no effect and respond SLVERR (2'b10); reads return rdata=0 and rresp=SLVERR.
REQ-010 In-range accesses SHALL respond OKAY (2'b00).
REQ-011 The write path SHALL hold flags aw_held and w_held plus latched awaddr, wdata and wstrb.
REQ-012 awready SHALL equal !aw_held && !bvalid, and wready SHALL equal !w_held && !bvalid.
REQ-013 AW and W SHALL be accepted independently, in either order or in the same cycle.
REQ-014 On the clock edge where the second of AW/W completes (or both complete together), the target register SHALL be updated per byte where wstrb[b]=1, the flags SHALL clear, and bvalid SHALL be set with the latched response.
REQ-015 The write-response latency SHALL therefore be 1 cycle after the completing handshake.
REQ-016 bvalid and bresp SHALL hold stable until bready=1, and bvalid SHALL clear on that edge.
REQ-017 No new AW or W SHALL be accepted while bvalid=1; the next AW/W may be accepted in the cycle after the B handshake.
REQ-018 arready SHALL equal !rvalid.
REQ-019 On an AR handshake, rdata and rresp SHALL be captured from the current register value (pre-edge) and rvalid SHALL set (latency 1 cycle).
REQ-020 rvalid, rdata and rresp SHALL hold stable until rready=1, and rvalid SHALL clear on that edge.
REQ-021 Maximum read throughput SHALL be one read per 2 cycles.
REQ-022 The read and write paths SHALL be fully independent.
REQ-023 For a read handshake on the same edge as a write commit to the same register, the read SHALL return the old value.
REQ-024 Valid signals SHALL never depend combinationally on ready signals, and a valid SHALL never drop before its handshake.
REQ-025 regs_o SHALL reflect register contents registered, updating the cycle after commit.

Reset
REQ-026 With aresetn=0 at a rising aclk edge: all registers, aw_held, w_held, bvalid and rvalid SHALL be 0; bresp, rresp and rdata SHALL be 0; regs_o SHALL be 0.
REQ-027 During reset, awready, wready and arready SHALL be 0 (gated by reset), and SHALL become 1 in the first cycle with aresetn=1.
REQ-028 A reset mid-transaction SHALL discard held AW/W and pending B/R responses, with no register update.

Structure
REQ-029 RESP_OKAY (2'b00) and RESP_SLVERR (2'b10) SHALL live in the shared package axi_lite_pkg alongside the axi_lite_if definitions.
REQ-030 No sub-module SHALL be used; the block is a single module of two independent channel controllers.

Verification
REQ-031 The bench SHALL cover: AW addr 0x4 and W 0xDEADBEEF strb 4'hF in the same cycle, bready=1 -> bvalid 1 cycle later, bresp=00, regs_o[1]=0xDEADBEEF.
REQ-032 The bench SHALL cover: W 0x11223344 strb 4'b0101 three cycles before AW addr 0x8, with register 2 preset to 0xAABBCCDD -> awready stays 1 while wready is 0 after W; result 0xAA22CC44 and bvalid 1 cycle after AW.
REQ-033 The bench SHALL cover: write to 0x20 with N_REGS=8 -> bresp=10 and all registers unchanged; read 0x20 -> rdata=0, rresp=10.
REQ-034 The bench SHALL cover: bready and rready held 0 for 5 cycles -> bvalid/rvalid and their data stable for those 5 cycles, awready/wready/arready=0 throughout, clearing on the handshake edge.
REQ-035 The bench SHALL cover: register 3=0x5, AR 0xC on the same edge as a write commit of 0x9 to 0xC -> rdata=0x5, and a following read returns 0x9.
REQ-036 The bench SHALL cover: aresetn=0 for one cycle while AW is held and B is pending -> all valids 0, no register change, readies 1 the cycle after release.
